// File: rtl/lane_rect_plotter.sv
// lane_rect_plotter: queued lane-rectangle fill and full-screen clear engine
// driving a VGA plot interface, one pixel per clock in raster order.
// Optional macro TILE_BORDER_EN adds a per-command border colour for the
// rectangle's outer edge pixels.
module lane_rect_plotter #(
  parameter int unsigned         LANES     = 4,
  parameter int unsigned         SCREEN_W  = 160,
  parameter int unsigned         SCREEN_H  = 120,
  parameter int unsigned         COORD_W   = 9,
  parameter int unsigned         COLOUR_W  = 9,
  parameter int unsigned         CMD_DEPTH = 4,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(LANES)-1:0]   cmd_lane,
  input  logic [COORD_W-1:0]         cmd_y,
  input  logic [COORD_W-1:0]         cmd_h,
  input  logic [COLOUR_W-1:0]        cmd_colour,
`ifdef TILE_BORDER_EN
  input  logic [COLOUR_W-1:0]        border_colour,
`endif
  input  logic                       clear_req,
  output logic [COORD_W-1:0]         x,
  output logic [COORD_W-1:0]         y,
  output logic [COLOUR_W-1:0]        colour,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned LANE_W    = SCREEN_W / LANES;
  localparam int unsigned PTR_W     = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned YS_W      = COORD_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  // Command FIFO storage
  logic [LANE_BITS-1:0] q_lane   [CMD_DEPTH];
  logic [COORD_W-1:0]   q_y      [CMD_DEPTH];
  logic [COORD_W-1:0]   q_h      [CMD_DEPTH];
  logic [COLOUR_W-1:0]  q_colour [CMD_DEPTH];
`ifdef TILE_BORDER_EN
  logic [COLOUR_W-1:0]  q_border [CMD_DEPTH];
  logic [COLOUR_W-1:0]  w_border, w_border_n;
  logic                 on_edge;
`endif

  logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0]     count, count_n;
  logic                 push, pop;

  logic [1:0]           state, state_n;
  logic                 clear_pending, clear_pending_n;
  logic [LANE_BITS-1:0] w_lane, w_lane_n;
  logic [COORD_W-1:0]   w_y, w_y_n, w_h, w_h_n;
  logic [COLOUR_W-1:0]  w_colour, w_colour_n;
  logic [COORD_W-1:0]   x_first, x_last, y_first, y_last;
  logic [COORD_W-1:0]   x_first_n, x_last_n, y_first_n, y_last_n;
  logic [COORD_W-1:0]   x_n, y_n, nx, ny;
  logic [COLOUR_W-1:0]  colour_n;
  logic                 plot_n, done_n, busy_n, ready_n;
  logic [YS_W-1:0]      y_sum, y_end;
  logic [31:0]          x0_full;

  // Next-state, FIFO bookkeeping and next pixel computation
  always_comb begin
    state_n         = state;
    clear_pending_n = clear_pending;
    pop             = 1'b0;
    w_lane_n        = w_lane;
    w_y_n           = w_y;
    w_h_n           = w_h;
    w_colour_n      = w_colour;
`ifdef TILE_BORDER_EN
    w_border_n      = w_border;
    on_edge         = 1'b0;
`endif
    x_first_n       = x_first;
    x_last_n        = x_last;
    y_first_n       = y_first;
    y_last_n        = y_last;
    x_n             = x;
    y_n             = y;
    colour_n        = colour;
    plot_n          = 1'b0;
    done_n          = 1'b0;
    nx              = x;
    ny              = y;
    y_sum           = YS_W'(w_y) + YS_W'(w_h);
    y_end           = (y_sum > YS_W'(SCREEN_H)) ? YS_W'(SCREEN_H) : y_sum;
    x0_full         = 32'(w_lane) * 32'(LANE_W);
    push            = cmd_valid && (count != CNT_W'(CMD_DEPTH));

    case (state)
      S_IDLE: begin
        if (clear_pending) begin
          clear_pending_n = 1'b0;
          x_first_n       = '0;
          x_last_n        = COORD_W'(SCREEN_W - 1);
          y_first_n       = '0;
          y_last_n        = COORD_W'(SCREEN_H - 1);
          nx              = '0;
          ny              = '0;
          plot_n          = 1'b1;
          state_n         = S_CLEAR;
        end else if (count != '0) begin
          pop        = 1'b1;
          w_lane_n   = q_lane[rd_ptr];
          w_y_n      = q_y[rd_ptr];
          w_h_n      = q_h[rd_ptr];
          w_colour_n = q_colour[rd_ptr];
`ifdef TILE_BORDER_EN
          w_border_n = q_border[rd_ptr];
`endif
          state_n    = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((w_h == '0) || (32'(w_y) >= 32'(SCREEN_H)) ||
            (x0_full >= 32'(SCREEN_W))) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          x_first_n = COORD_W'(x0_full);
          x_last_n  = COORD_W'(x0_full + 32'(LANE_W) - 32'd1);
          y_first_n = w_y;
          y_last_n  = COORD_W'(y_end - YS_W'(1));
          nx        = COORD_W'(x0_full);
          ny        = w_y;
          plot_n    = 1'b1;
          state_n   = S_FILL;
        end
      end
      S_FILL, S_CLEAR: begin
        // done marks the pixel currently on the outputs as the last one
        if (done) begin
          state_n = S_IDLE;
        end else begin
          plot_n = 1'b1;
          if (x == x_last) begin
            nx = x_first;
            ny = y + COORD_W'(1);
          end else begin
            nx = x + COORD_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (plot_n) begin
      x_n    = nx;
      y_n    = ny;
      done_n = (nx == x_last_n) && (ny == y_last_n);
`ifdef TILE_BORDER_EN
      on_edge  = (nx == x_first_n) || (nx == x_last_n) ||
                 (ny == y_first_n) || (ny == y_last_n);
      colour_n = (state_n == S_CLEAR) ? BG_COLOUR :
                 (on_edge ? w_border_n : w_colour_n);
`else
      colour_n = (state_n == S_CLEAR) ? BG_COLOUR : w_colour_n;
`endif
    end

    if (clear_req) clear_pending_n = 1'b1;

    wr_ptr_n = wr_ptr + PTR_W'(push);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    count_n  = count + CNT_W'(push) - CNT_W'(pop);
    ready_n  = (count_n != CNT_W'(CMD_DEPTH));
    busy_n   = (state_n != S_IDLE) || (count_n != '0) || clear_pending_n;
  end

  // FIFO entry write on accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      q_lane[wr_ptr]   <= cmd_lane;
      q_y[wr_ptr]      <= cmd_y;
      q_h[wr_ptr]      <= cmd_h;
      q_colour[wr_ptr] <= cmd_colour;
`ifdef TILE_BORDER_EN
      q_border[wr_ptr] <= border_colour;
`endif
    end
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      clear_pending <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      w_lane        <= '0;
      w_y           <= '0;
      w_h           <= '0;
      w_colour      <= '0;
`ifdef TILE_BORDER_EN
      w_border      <= '0;
`endif
      x_first       <= '0;
      x_last        <= '0;
      y_first       <= '0;
      y_last        <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
    end else begin
      state         <= state_n;
      clear_pending <= clear_pending_n;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      count         <= count_n;
      w_lane        <= w_lane_n;
      w_y           <= w_y_n;
      w_h           <= w_h_n;
      w_colour      <= w_colour_n;
`ifdef TILE_BORDER_EN
      w_border      <= w_border_n;
`endif
      x_first       <= x_first_n;
      x_last        <= x_last_n;
      y_first       <= y_first_n;
      y_last        <= y_last_n;
      x             <= x_n;
      y             <= y_n;
      colour        <= colour_n;
      plot          <= plot_n;
      done          <= done_n;
      busy          <= busy_n;
      cmd_ready     <= ready_n;
    end
  end

endmodule

// File: tb/tb_lane_rect_plotter.sv
// Directed self-checking bench for lane_rect_plotter (default parameters).
// Border checks run only when TILE_BORDER_EN is defined.
module tb_lane_rect_plotter;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_lane;
  logic [8:0] cmd_y;
  logic [8:0] cmd_h;
  logic [8:0] cmd_colour;
`ifdef TILE_BORDER_EN
  logic [8:0] border_colour;
`endif
  logic       clear_req;
  logic [8:0] x;
  logic [8:0] y;
  logic [8:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  lane_rect_plotter dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_lane      (cmd_lane),
    .cmd_y         (cmd_y),
    .cmd_h         (cmd_h),
    .cmd_colour    (cmd_colour),
`ifdef TILE_BORDER_EN
    .border_colour (border_colour),
`endif
    .clear_req     (clear_req),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-operation record: one entry per done pulse
  int op_n = 0;
  int seg_pix = 0;
  int seg_fx = 0;
  int seg_fy = 0;
  int plots_total = 0;
  int n1ff = 0;
  int n1ff_int = 0;
  int op_pix [64];
  int op_fx  [64];
  int op_fy  [64];
  int op_lx  [64];
  int op_ly  [64];
  int op_lc  [64];
  int op_dp  [64];

  // Output monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      seg_pix = 0;
    end else begin
      if (plot) begin
        if (seg_pix == 0) begin
          seg_fx = int'(x);
          seg_fy = int'(y);
        end
        seg_pix++;
        plots_total++;
        if (colour == 9'h1FF) begin
          n1ff++;
          if (y == 9'd1 && x >= 9'd1 && x <= 9'd38) n1ff_int++;
        end
      end
      if (done) begin
        if (op_n < 64) begin
          op_pix[op_n] = seg_pix;
          op_fx[op_n]  = seg_fx;
          op_fy[op_n]  = seg_fy;
          op_lx[op_n]  = int'(x);
          op_ly[op_n]  = int'(y);
          op_lc[op_n]  = int'(colour);
          op_dp[op_n]  = int'(plot);
        end
        op_n++;
        seg_pix = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input int lane, input int cy, input int ch, input int col);
    cmd_valid  = 1'b1;
    cmd_lane   = 2'(lane);
    cmd_y      = 9'(cy);
    cmd_h      = 9'(ch);
    cmd_colour = 9'(col);
`ifdef TILE_BORDER_EN
    border_colour = 9'(col);
`endif
  endtask

  task automatic wait_ops(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (op_n >= target) break;
    end
    check(tag, 32'(op_n >= target), 32'd1);
  endtask

  task automatic check_op(input string tag, input int k, input int pix, input int fx, input int fy,
                          input int lx, input int ly, input int lc, input int dp);
    check({tag, "_pix"}, 32'(op_pix[k]), 32'(pix));
    check({tag, "_first_x"}, 32'(op_fx[k]), 32'(fx));
    check({tag, "_first_y"}, 32'(op_fy[k]), 32'(fy));
    check({tag, "_last_x"}, 32'(op_lx[k]), 32'(lx));
    check({tag, "_last_y"}, 32'(op_ly[k]), 32'(ly));
    check({tag, "_last_col"}, 32'(op_lc[k]), 32'(lc));
    check({tag, "_done_plot"}, 32'(op_dp[k]), 32'(dp));
  endtask

  initial begin
    int snap_p;
    int snap_o;
    int snap_a;
    int snap_b;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_lane   = '0;
    cmd_y      = '0;
    cmd_h      = '0;
    cmd_colour = '0;
`ifdef TILE_BORDER_EN
    border_colour = '0;
`endif
    clear_req  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fill lane 1, rows 10..12: latency, first and last pixel, busy drop
    drive_cmd(1, 10, 3, 9'h1C0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t1_lat0_plot", 32'(plot), 32'd0);
    @(negedge clk);
    check("t1_lat1_plot", 32'(plot), 32'd0);
    @(negedge clk);
    check("t1_first_plot", 32'(plot), 32'd1);
    check("t1_first_x", 32'(x), 32'd40);
    check("t1_first_y", 32'(y), 32'd10);
    check("t1_first_col", 32'(colour), 32'h1C0);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_x", 32'(x), 32'd79);
    check("t1_done_y", 32'(y), 32'd12);
    check("t1_done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_after_busy", 32'(busy), 32'd0);
    check("t1_after_plot", 32'(plot), 32'd0);
    check("t1_after_x_hold", 32'(x), 32'd79);
    check_op("t1", 0, 120, 40, 10, 79, 12, 9'h1C0, 1);

    // Fill clipped at the bottom of the screen
    drive_cmd(3, 115, 20, 9'h155);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ops(2, 400, "t2_wait");
    check_op("t2", 1, 200, 120, 115, 159, 119, 9'h155, 1);

    // Zero-height command and off-screen command: done with no pixels
    snap_p = plots_total;
    drive_cmd(0, 5, 0, 9'h0AA);
    @(negedge clk);
    drive_cmd(2, 130, 5, 9'h0AB);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ops(4, 50, "t3_wait");
    check("t3_no_plots", 32'(plots_total - snap_p), 32'd0);
    check("t3_op0_pix", 32'(op_pix[2]), 32'd0);
    check("t3_op0_plot", 32'(op_dp[2]), 32'd0);
    check("t3_op1_pix", 32'(op_pix[3]), 32'd0);
    check("t3_op1_plot", 32'(op_dp[3]), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(cmd_ready), 32'd1);

    // Fill the FIFO during a clear; the 5th push must be dropped
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    drive_cmd(0, 0, 1, 9'h011);
    @(negedge clk);
    drive_cmd(1, 0, 1, 9'h022);
    @(negedge clk);
    drive_cmd(2, 0, 1, 9'h033);
    @(negedge clk);
    drive_cmd(3, 0, 1, 9'h044);
    @(negedge clk);
    check("t4_ready_full", 32'(cmd_ready), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    drive_cmd(0, 50, 2, 9'h1FF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t4_ready_still_full", 32'(cmd_ready), 32'd0);
    wait_ops(9, 21000, "t4_wait");
    check_op("t4_clr", 4, 19200, 0, 0, 159, 119, 0, 1);
    check_op("t4_f0", 5, 40, 0, 0, 39, 0, 9'h011, 1);
    check_op("t4_f1", 6, 40, 40, 0, 79, 0, 9'h022, 1);
    check_op("t4_f2", 7, 40, 80, 0, 119, 0, 9'h033, 1);
    check_op("t4_f3", 8, 40, 120, 0, 159, 0, 9'h044, 1);
    repeat (100) @(negedge clk);
    check("t4_no_fifth", 32'(op_n), 32'd9);

    // Clear requested mid-fill runs after the fill, before the queued command
    drive_cmd(2, 20, 4, 9'h0AA);
    @(negedge clk);
    drive_cmd(0, 100, 2, 9'h0BB);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_mid_fill_plot", 32'(plot), 32'd1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_ops(12, 21000, "t5_wait");
    check_op("t5_fill", 9, 160, 80, 20, 119, 23, 9'h0AA, 1);
    check_op("t5_clr", 10, 19200, 0, 0, 159, 119, 0, 1);
    check_op("t5_queued", 11, 80, 0, 100, 39, 101, 9'h0BB, 1);

    // Reset mid-fill with a command still queued
    drive_cmd(1, 0, 10, 9'h0CC);
    @(negedge clk);
    drive_cmd(2, 0, 10, 9'h0DD);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_pre_plot", 32'(plot), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_plot", 32'(plot), 32'd0);
    check("t6_rst_ready", 32'(cmd_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    snap_p = plots_total;
    snap_o = op_n;
    repeat (60) @(negedge clk);
    check("t6_no_pixels", 32'(plots_total - snap_p), 32'd0);
    check("t6_no_ops", 32'(op_n - snap_o), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

`ifdef TILE_BORDER_EN
    // Border colour on the outer edge, fill colour only in the interior
    snap_a = n1ff;
    snap_b = n1ff_int;
    drive_cmd(0, 0, 3, 9'h1FF);
    border_colour = 9'h007;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ops(snap_o + 1, 300, "tb_wait");
    check_op("tb", snap_o, 120, 0, 0, 39, 2, 9'h007, 1);
    check("tb_interior_cnt", 32'(n1ff - snap_a), 32'd38);
    check("tb_interior_pos", 32'(n1ff_int - snap_b), 32'd38);
`else
    snap_a = 0;
    snap_b = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_rect_plotter.md
Name: lane_rect_plotter

Overview:
- Parametrised rectangle-fill engine between the game state manager and the VGA adapter's plot interface (x, y, colour, plot).
- Accepts queued "fill lane rectangle" commands and full-screen clear requests, then emits exactly one pixel per clock in raster order.
- Generalises the fixed 4-lane, 160x120, 9-bit-colour plotting into configurable lane count, resolution, colour depth and command buffering.

Parameters:
- LANES, 4: number of equal-width vertical lanes; must divide SCREEN_W exactly.
- SCREEN_W, 160: screen width in pixels.
- SCREEN_H, 120: screen height in pixels.
- COORD_W, 9: width of x/y coordinates; 2^COORD_W > max(SCREEN_W, SCREEN_H).
- COLOUR_W, 9: colour word width.
- CMD_DEPTH, 4: command FIFO depth; power of 2, >= 2.
- BG_COLOUR, 0: colour used by clear.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_lane  in  $clog2(LANES)  target lane index.
- cmd_y  in  COORD_W  top row of rectangle.
- cmd_h  in  COORD_W  rectangle height in rows.
- cmd_colour  in  COLOUR_W  fill colour.
- clear_req  in  1  single-cycle pulse; request a full-screen clear.
- x  out  COORD_W  pixel x.
- y  out  COORD_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  pixel write enable.
- busy  out  1  high while in FILL or CLEAR, or while the FIFO is non-empty or a clear is pending.
- done  out  1  one-cycle pulse accompanying the final pixel of an operation, or marking a zero-pixel operation.

Behaviour:
- Reset values: x=0, y=0, colour=0, plot=0, done=0, busy=0. FIFO emptied, clear_pending=0, state IDLE.
- Reset takes effect immediately, including mid-operation. No further pixels are emitted after reset asserts.
- LANE_W = SCREEN_W/LANES. Lane L spans x = L*LANE_W .. L*LANE_W+LANE_W-1.
- FIFO push on cmd_valid && cmd_ready. cmd_ready = !full. A push while full is ignored.
- A push and a pop in the same cycle are both performed.
- A clear_req pulse sets clear_pending. Further pulses while pending are absorbed.
- States:
  - IDLE: if clear_pending, clear it and go to CLEAR. Else if the FIFO is non-empty, pop into the working registers and go to LOAD. Clear has priority over queued commands.
  - LOAD: compute y_end = min(cmd_y + cmd_h, SCREEN_H), using COORD_W+1-bit arithmetic with no wrap.
    - If cmd_h == 0, cmd_y >= SCREEN_H, or cmd_lane >= LANES: pulse done with plot=0, then go to IDLE.
    - Otherwise go to FILL starting at (lane x0, cmd_y).
  - FILL: plot=1 every cycle. x increments; at the lane's right edge x wraps to x0 and y increments. The last pixel is (x0+LANE_W-1, y_end-1); done=1 in that same cycle, then go to IDLE.
  - CLEAR: same sweep over the whole screen, (0,0) to (SCREEN_W-1, SCREEN_H-1), with colour=BG_COLOUR. done accompanies pixel (SCREEN_W-1, SCREEN_H-1).
- Outputs are registered. A command pushed in cycle N into an empty FIFO in IDLE produces its first plot in cycle N+3: pop in N+1, LOAD in N+2, first pixel in N+3.
- Pixel count: LANE_W*(y_end-cmd_y) for a fill, SCREEN_W*SCREEN_H for a clear.
- A clear_req arriving mid-FILL or mid-CLEAR does not abort the operation. It runs after the current operation completes.
- plot=0 in IDLE and LOAD. x, y and colour hold their last values when plot=0.

Optional Feature:
- TILE_BORDER_EN:
  - When defined, adds input border_colour [COLOUR_W]. It is sampled at FIFO push and stored per entry.
  - During FILL, pixels on the rectangle's outer edge (x==x0, x==x0+LANE_W-1, y==cmd_y, y==y_end-1) use border_colour; interior pixels use cmd_colour.
  - Clipped rows form the bottom edge.
  - When undefined, the port is absent and all fill pixels use cmd_colour.

Test Plan:
- Reset, then push lane=1, y=10, h=3, colour=9'h1C0 into an empty FIFO -> first plot 3 cycles after the push at (40,10). 120 plots ending at (79,12) with done in the same cycle. busy drops one cycle later.
- Push lane=3, y=115, h=20 -> clipped to rows 115..119. 200 plots, last at (159,119).
- Push h=0, then push y=130 -> no plots, 2 done pulses, FIFO drains.
- Fill the FIFO with 4 commands while a clear runs -> cmd_ready=0 after the 4th push. A 5th push is ignored. Exactly 4 fills follow the 19200-pixel clear.
- clear_req during a fill, with a command queued behind it -> the fill completes, then the clear runs with colour=BG_COLOUR, then the queued command runs.
- Assert reset mid-FILL -> plot=0 immediately, cmd_ready=1, busy=0, and no pixels after reset is released without new input.
- TILE_BORDER_EN: lane=0, y=0, h=3, border=9'h007, colour=9'h1FF -> only row 1, x=1..38 is 9'h1FF; all other pixels are 9'h007.
